crank_sim: RTL and testbench
============================

# crank_sim

Synthesisable crank trigger-wheel generator for a TEETH-minus-MISSING pattern (default 60-2). It produces the tooth waveform that the angle-generator capture input expects, at a programmable tooth period in clock cycles. The block sits on the bench/self-test side of the design and drives the capture pin of the angle generator, either by loopback or through an external pin. It also provides tooth-index, gap and revolution markers so checkers can correlate the generated angle with the decoded angle.

## Interface
Parameters:
- PERIOD_WIDTH, 24, width of the tooth-period input and of the phase counter.
- TEETH, 60, tooth slots per revolution, including missing ones. Legal range is 3..255.
- MISSING, 2, number of missing slots at the end of the revolution. Legal range is 0..TEETH-2.

Ports:
- clk, input, 1, the only clock.
- rst, input, 1, asynchronous, active-high reset.
- ena, input, 1, run enable.
- period, input, PERIOD_WIDTH, clocks per tooth slot.
- crank_out, output, 1, generated wheel signal, with a rising edge at the start of each present tooth.
- tooth_idx, output, 8, current slot number, 0..TEETH-1.
- gap_strobe, output, 1, one-cycle pulse on the first cycle of slot TEETH-MISSING.
- rev_strobe, output, 1, one-cycle pulse on the first cycle of slot 0.
- cam_out, output, 1, cam marker; exists only with CRANK_SIM_CAM_EN.

## Operation
- States:
  - IDLE: crank_out = 0 and all counters are cleared.
  - HIGH: first half of a present tooth.
  - LOW: second half of a present tooth.
  - GAP: an entire missing slot.
- Period latch:
  - P_eff = max(period, 2).
  - P_eff is latched on the IDLE→run transition and on every slot-boundary cycle.
  - Each slot uses the P_eff latched at its start. A change to period in mid-slot takes effect from the next slot.
- Slot timing:
  - The phase counter pcnt runs 0..P_eff-1.
  - For a present slot (tooth_idx < TEETH-MISSING), crank_out is high while pcnt < P_eff>>1 and low for the remaining P_eff-(P_eff>>1) cycles.
  - For a missing slot, crank_out is low for all P_eff cycles.
- Slot boundary (pcnt == P_eff-1):
  - pcnt returns to 0.
  - tooth_idx increments, wrapping from TEETH-1 to 0.
  - The next state is HIGH or GAP according to the new index.
- Transitions:
  - IDLE→HIGH with tooth_idx = 0 when ena = 1.
  - Any state→IDLE on the cycle after ena is sampled low. Counters are cleared and the slot is not completed.
- Strobes: gap_strobe and rev_strobe are registered and coincide with the first cycle of their slot. rev_strobe also fires on the first tooth after leaving IDLE.
- MISSING = 0: GAP is unreachable and gap_strobe never fires.
- Reset values: state IDLE; crank_out, tooth_idx, pcnt, gap_strobe, rev_strobe, cam_out and rev_parity all 0; latched period 2.

## Timing
- All outputs are registered with no combinational path from inputs.
- ena is sampled high at edge k → crank_out = 1, tooth_idx = 0 and rev_strobe = 1 from edge k+1.
- Revolution length is the sum of the per-slot P_eff values. With constant P this is TEETH·P cycles.
- The falling edge inside a tooth occurs P_eff>>1 cycles after its rising edge.
- rst asserted at any time forces the reset values immediately (asynchronous). After release, the block starts from IDLE.

## Configuration
- CRANK_SIM_CAM_EN defined:
  - Adds a rev_parity flop that toggles on every wrap from TEETH-1 to 0.
  - cam_out = 1 for the whole of slot 10 when rev_parity = 0, giving one pulse per two revolutions (720°). Otherwise cam_out = 0.
  - cam_out is registered and aligned with crank_out.
- CRANK_SIM_CAM_EN undefined: no cam_out port and no rev_parity flop.

## Structure
- Package crank_sim_pkg holds:
  - the state enum crank_sim_state_t (IDLE, HIGH, LOW, GAP);
  - the constants CRANK_SIM_TEETH_DEF = 60, CRANK_SIM_MISSING_DEF = 2 and CRANK_SIM_P_MIN = 2.
- Sub-module crank_sim_slot_cnt holds the phase counter with the period latch and the end-of-slot compare. The FSM, tooth index and strobes stay in the top level.

## Test plan
- Wheel pattern: P = 8, default 60-2, ena raised at cycle 0:
  - crank_out is high on cycles 1-4 and low on cycles 5-8 of each tooth;
  - 58 rising edges occur per revolution;
  - slots 58-59 give 16 low cycles;
  - rev_strobe pulses are exactly 480 cycles apart.
- Mid-slot period change: period changed from 8 to 12 during slot 3 → slot 3 lasts 8 cycles and slot 4 lasts 12 cycles (6 high, 6 low).
- Period clamp: period = 0 and then period = 1 → in both cases a tooth lasts 2 cycles, 1 high and 1 low.
- Disable and reset mid-operation:
  - ena dropped in slot 20 → crank_out = 0 and tooth_idx = 0 on the next cycle.
  - rst pulsed in slot 30 → all outputs read 0 immediately.
  - A restart with ena = 1 begins again at slot 0.
- Gap strobe and loopback: gap_strobe is high exactly on the first cycle of slot 58. With crank_out looped into the angle generator at P = 1024, the angle generator's gap detection asserts once per revolution.
- Cam marker: with CRANK_SIM_CAM_EN and P = 8, cam_out is high for 8 cycles in slot 10 of the first revolution, low throughout the second, and high again in the third.

Source files
------------

// File: rtl/crank_sim_pkg.sv
// crank_sim_pkg: shared types and defaults for the crank trigger-wheel generator.
package crank_sim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        GAP
    } crank_sim_state_t;

    localparam int unsigned CRANK_SIM_TEETH_DEF   = 60;
    localparam int unsigned CRANK_SIM_MISSING_DEF = 2;
    localparam int unsigned CRANK_SIM_P_MIN       = 2;
    localparam int unsigned CRANK_SIM_CAM_SLOT    = 10;

endpackage

// File: rtl/crank_sim_slot_cnt.sv
// crank_sim_slot_cnt: per-slot phase counter with period latch and slot-end / half-slot compares.
module crank_sim_slot_cnt
    import crank_sim_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    clr,
    input  logic                    adv,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    slot_end_c,
    output logic                    half_end_c
);

    localparam logic [PERIOD_WIDTH-1:0] P_MIN = PERIOD_WIDTH'(CRANK_SIM_P_MIN);
    localparam logic [PERIOD_WIDTH-1:0] ONE   = PERIOD_WIDTH'(1);

    logic [PERIOD_WIDTH-1:0] pcnt;
    logic [PERIOD_WIDTH-1:0] p_lat;
    logic [PERIOD_WIDTH-1:0] p_eff_c;

    // Periods below two cannot hold both a high and a low phase, so clamp them.
    assign p_eff_c    = (period < P_MIN) ? P_MIN : period;
    assign slot_end_c = (pcnt == p_lat - ONE);
    assign half_end_c = (pcnt == (p_lat >> 1) - ONE);

    // Phase counter; the period is captured only at run start and slot boundaries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt  <= '0;
            p_lat <= P_MIN;
        end else if (start) begin
            pcnt  <= '0;
            p_lat <= p_eff_c;
        end else if (clr) begin
            pcnt  <= '0;
        end else if (adv) begin
            if (slot_end_c) begin
                pcnt  <= '0;
                p_lat <= p_eff_c;
            end else begin
                pcnt  <= pcnt + ONE;
            end
        end
    end

endmodule

// File: rtl/crank_sim.sv
// crank_sim: TEETH-minus-MISSING trigger-wheel generator with tooth index and gap/rev markers.
// Optional cam marker (one pulse per two revolutions) enabled by defining CRANK_SIM_CAM_EN.
module crank_sim
    import crank_sim_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH = 24,
    parameter int unsigned TEETH        = CRANK_SIM_TEETH_DEF,
    parameter int unsigned MISSING      = CRANK_SIM_MISSING_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    crank_out,
    output logic [7:0]              tooth_idx,
    output logic                    gap_strobe,
    output logic                    rev_strobe
`ifdef CRANK_SIM_CAM_EN
    ,
    output logic                    cam_out
`endif
);

    localparam logic [7:0] LAST_SLOT = 8'(TEETH - 1);
    localparam logic [7:0] GAP_SLOT  = 8'(TEETH - MISSING);
    localparam bit         HAS_GAP   = (MISSING != 0);

    crank_sim_state_t state;
    logic             running_c;
    logic             start_c;
    logic             clr_c;
    logic             adv_c;
    logic             slot_end_c;
    logic             half_end_c;
    logic             wrap_c;
    logic [7:0]       idx_next_c;

    assign running_c  = (state != IDLE);
    assign start_c    = !running_c && ena;
    assign clr_c      = running_c && !ena;
    assign adv_c      = running_c && ena;
    assign wrap_c     = (tooth_idx == LAST_SLOT);
    assign idx_next_c = wrap_c ? 8'd0 : tooth_idx + 8'd1;

    crank_sim_slot_cnt #(
        .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_slot_cnt (
        .clk       (clk),
        .rst       (rst),
        .start     (start_c),
        .clr       (clr_c),
        .adv       (adv_c),
        .period    (period),
        .slot_end_c(slot_end_c),
        .half_end_c(half_end_c)
    );

    // Wheel FSM: tooth phases, slot index and single-cycle markers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            crank_out  <= 1'b0;
            tooth_idx  <= 8'd0;
            gap_strobe <= 1'b0;
            rev_strobe <= 1'b0;
        end else begin
            gap_strobe <= 1'b0;
            rev_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (ena) begin
                        state      <= HIGH;
                        crank_out  <= 1'b1;
                        tooth_idx  <= 8'd0;
                        rev_strobe <= 1'b1;
                    end
                end
                default: begin
                    if (!ena) begin
                        state     <= IDLE;
                        crank_out <= 1'b0;
                        tooth_idx <= 8'd0;
                    end else if (slot_end_c) begin
                        tooth_idx  <= idx_next_c;
                        rev_strobe <= wrap_c;
                        gap_strobe <= HAS_GAP && (idx_next_c == GAP_SLOT);
                        if (idx_next_c < GAP_SLOT) begin
                            state     <= HIGH;
                            crank_out <= 1'b1;
                        end else begin
                            state     <= GAP;
                            crank_out <= 1'b0;
                        end
                    end else if ((state == HIGH) && half_end_c) begin
                        state     <= LOW;
                        crank_out <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef CRANK_SIM_CAM_EN
    localparam logic [7:0] CAM_SLOT = 8'(CRANK_SIM_CAM_SLOT);

    logic rev_parity;
    logic parity_next_c;

    assign parity_next_c = rev_parity ^ wrap_c;

    // Cam marker: whole of the cam slot on even revolutions only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rev_parity <= 1'b0;
            cam_out    <= 1'b0;
        end else if (!adv_c) begin
            rev_parity <= 1'b0;
            cam_out    <= 1'b0;
        end else if (slot_end_c) begin
            rev_parity <= parity_next_c;
            cam_out    <= (idx_next_c == CAM_SLOT) && !parity_next_c;
        end
    end
`endif

endmodule

// File: tb/tb_crank_sim.sv
// tb_crank_sim: directed table, hand sequences and randomized run against a slot-level model.
module tb_crank_sim;

    localparam int TEETH   = 60;
    localparam int MISSING = 2;
    localparam int PW      = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic [PW-1:0] period;
    logic          crank_out;
    logic [7:0]    tooth_idx;
    logic          gap_strobe;
    logic          rev_strobe;
`ifdef CRANK_SIM_CAM_EN
    logic          cam_out;
`endif

    crank_sim #(
        .PERIOD_WIDTH(PW),
        .TEETH       (TEETH),
        .MISSING     (MISSING)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .period    (period),
        .crank_out (crank_out),
        .tooth_idx (tooth_idx),
        .gap_strobe(gap_strobe),
        .rev_strobe(rev_strobe)
`ifdef CRANK_SIM_CAM_EN
        ,
        .cam_out   (cam_out)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: whether running, slot number, position in slot, slot length, revolutions wrapped.
    bit m_run;
    int m_slot, m_pos, m_len, m_wraps;

    typedef struct {
        bit e;
        int p;
        int n;
        bit crank;
        int idx;
        bit gap;
        bit rev;
    } vec_t;
    vec_t tbl[$];

    int revs, rises, gaps, gap_low, highs, t0, t1, n3, n4, h4;
    bit prev;
    int camc[3];

    task automatic model_reset();
        m_run = 0; m_slot = 0; m_pos = 0; m_len = 2; m_wraps = 0;
    endtask

    task automatic model_edge(input bit e, input int p);
        int pe;
        pe = (p < 2) ? 2 : p;
        if (!m_run) begin
            if (e) begin
                m_run = 1; m_slot = 0; m_pos = 0; m_len = pe; m_wraps = 0;
            end
        end else if (!e) begin
            m_run = 0; m_slot = 0; m_pos = 0; m_wraps = 0;
        end else begin
            m_pos++;
            if (m_pos == m_len) begin
                m_pos = 0;
                m_len = pe;
                if (m_slot == TEETH - 1) begin
                    m_slot = 0;
                    m_wraps++;
                end else begin
                    m_slot++;
                end
            end
        end
    endtask

    function automatic logic [11:0] exp_vec();
        logic       c, g, r, cm;
        logic [7:0] i;
        c  = m_run && (m_slot < TEETH - MISSING) && (m_pos < m_len / 2);
        i  = m_run ? 8'(m_slot) : 8'd0;
        g  = m_run && (MISSING > 0) && (m_slot == TEETH - MISSING) && (m_pos == 0);
        r  = m_run && (m_slot == 0) && (m_pos == 0);
        cm = 1'b0;
`ifdef CRANK_SIM_CAM_EN
        cm = m_run && (m_slot == 10) && (m_wraps % 2 == 0);
`endif
        return {c, i, g, r, cm};
    endfunction

    function automatic logic [11:0] dut_vec();
`ifdef CRANK_SIM_CAM_EN
        return {crank_out, tooth_idx, gap_strobe, rev_strobe, cam_out};
`else
        return {crank_out, tooth_idx, gap_strobe, rev_strobe, 1'b0};
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: inputs already stable, advance model on the edge, compare at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge(ena, int'(period));
        @(negedge clk);
        cyc++;
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL model cyc=%0d dut=%h exp=%h", cyc, dut_vec(), exp_vec());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ena = 1'b0;
        #1;
        chk("rst_crank", int'(crank_out), 0);
        chk("rst_idx", int'(tooth_idx), 0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst    = 1'b1;
        ena    = 1'b0;
        period = PW'(8);
        model_reset();
        @(negedge clk);
        chk("reset_crank", int'(crank_out), 0);
        chk("reset_idx", int'(tooth_idx), 0);
        chk("reset_gap", int'(gap_strobe), 0);
        chk("reset_rev", int'(rev_strobe), 0);
        rst = 1'b0;

        // Directed table: {ena, period, cycles} followed by expected outputs.
        tbl.push_back('{0, 8, 1,   0, 0,  0, 0});
        tbl.push_back('{1, 8, 1,   1, 0,  0, 1});
        tbl.push_back('{1, 8, 3,   1, 0,  0, 0});
        tbl.push_back('{1, 8, 1,   0, 0,  0, 0});
        tbl.push_back('{1, 8, 4,   1, 1,  0, 0});
        tbl.push_back('{1, 8, 456, 0, 58, 1, 0});
        tbl.push_back('{1, 8, 1,   0, 58, 0, 0});
        tbl.push_back('{1, 8, 15,  1, 0,  0, 1});
        tbl.push_back('{1, 0, 8,   1, 1,  0, 0});
        tbl.push_back('{1, 0, 1,   0, 1,  0, 0});
        tbl.push_back('{1, 1, 1,   1, 2,  0, 0});
        tbl.push_back('{1, 1, 1,   0, 2,  0, 0});
        tbl.push_back('{0, 8, 1,   0, 0,  0, 0});
        tbl.push_back('{0, 8, 2,   0, 0,  0, 0});
        tbl.push_back('{1, 3, 1,   1, 0,  0, 1});
        tbl.push_back('{1, 3, 1,   0, 0,  0, 0});
        tbl.push_back('{1, 3, 2,   1, 1,  0, 0});
        foreach (tbl[k]) begin
            ena    = tbl[k].e;
            period = PW'(tbl[k].p);
            repeat (tbl[k].n) tick();
            chk($sformatf("tbl%0d_crank", k), int'(crank_out), int'(tbl[k].crank));
            chk($sformatf("tbl%0d_idx", k), int'(tooth_idx), tbl[k].idx);
            chk($sformatf("tbl%0d_gap", k), int'(gap_strobe), int'(tbl[k].gap));
            chk($sformatf("tbl%0d_rev", k), int'(rev_strobe), int'(tbl[k].rev));
        end

        // Wheel pattern over one full revolution at P = 8.
        do_reset();
        period = PW'(8);
        ena    = 1'b1;
        revs = 0; rises = 0; gaps = 0; gap_low = 0; highs = 0; t0 = 0; t1 = 0; prev = 1'b0;
        for (int c = 0; c < 1200 && revs < 2; c++) begin
            tick();
            if (rev_strobe) begin
                revs++;
                if (revs == 1) t0 = cyc;
                if (revs == 2) t1 = cyc;
            end
            if (revs == 1) begin
                if (crank_out && !prev) rises++;
                if (crank_out) highs++;
                if (tooth_idx >= 8'd58 && !crank_out) gap_low++;
                if (gap_strobe) begin
                    gaps++;
                    chk("gap_at_58", int'(tooth_idx), 58);
                end
            end
            prev = crank_out;
        end
        chk("wheel_revs_seen", revs, 2);
        chk("wheel_rev_spacing", t1 - t0, 480);
        chk("wheel_rises", rises, 58);
        chk("wheel_high_cycles", highs, 232);
        chk("wheel_gap_low", gap_low, 16);
        chk("wheel_gap_strobes", gaps, 1);

        // Period change in the middle of slot 3.
        do_reset();
        period = PW'(8);
        ena    = 1'b1;
        for (int c = 0; c < 100 && tooth_idx != 8'd3; c++) tick();
        chk("mid_reach3", int'(tooth_idx), 3);
        n3 = 1;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (tooth_idx == 8'd3) n3++;
        end
        period = PW'(12);
        for (int c = 0; c < 40 && tooth_idx == 8'd3; c++) begin
            tick();
            if (tooth_idx == 8'd3) n3++;
        end
        n4 = 0; h4 = 0;
        for (int c = 0; c < 40 && tooth_idx == 8'd4; c++) begin
            n4++;
            if (crank_out) h4++;
            tick();
        end
        chk("mid_slot3_len", n3, 8);
        chk("mid_slot4_len", n4, 12);
        chk("mid_slot4_high", h4, 6);

        // Disable in slot 20, asynchronous reset in slot 30, then restart.
        do_reset();
        period = PW'(8);
        ena    = 1'b1;
        for (int c = 0; c < 400 && tooth_idx != 8'd20; c++) tick();
        chk("dis_reach20", int'(tooth_idx), 20);
        repeat (3) tick();
        ena = 1'b0;
        tick();
        chk("dis_crank", int'(crank_out), 0);
        chk("dis_idx", int'(tooth_idx), 0);
        ena = 1'b1;
        for (int c = 0; c < 400 && tooth_idx != 8'd30; c++) tick();
        chk("rst_reach30", int'(tooth_idx), 30);
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_crank", int'(crank_out), 0);
        chk("arst_idx", int'(tooth_idx), 0);
        chk("arst_gap", int'(gap_strobe), 0);
        chk("arst_rev", int'(rev_strobe), 0);
        ena = 1'b0;
        #1 rst = 1'b0;
        model_reset();
        tick();
        ena = 1'b1;
        tick();
        chk("restart_idx", int'(tooth_idx), 0);
        chk("restart_rev", int'(rev_strobe), 1);
        chk("restart_crank", int'(crank_out), 1);

`ifdef CRANK_SIM_CAM_EN
        // Cam marker across three revolutions.
        do_reset();
        period = PW'(8);
        ena    = 1'b1;
        revs = 0;
        camc[0] = 0; camc[1] = 0; camc[2] = 0;
        for (int c = 0; c < 1600 && revs < 4; c++) begin
            tick();
            if (rev_strobe) revs++;
            if (revs >= 1 && revs <= 3 && cam_out) camc[revs-1]++;
        end
        chk("cam_revs_seen", revs, 4);
        chk("cam_rev1", camc[0], 8);
        chk("cam_rev2", camc[1], 0);
        chk("cam_rev3", camc[2], 8);
`endif

        // Randomized run: occasional enable drops and period changes, checked every cycle.
        do_reset();
        period = PW'(8);
        ena    = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (!ena) begin
                if ($urandom_range(0, 3) == 0) ena = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                ena = 1'b0;
            end
            if ($urandom_range(0, 24) == 0) period = PW'($urandom_range(0, 14));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
